// File: rtl/snes_mem_pkg.sv
// Shared types and constants for the cartridge memory responder: backend
// widths, FSM states, the BSRAM write-buffer entry and address helpers.
package snes_mem_pkg;

    localparam int MEM_AW  = 24;
    localparam int MEM_DW  = 16;
    localparam int MEM_BEW = 2;
    localparam int BS_AW   = 20;
    localparam int BS_DW   = 8;

    localparam logic [MEM_AW-1:0] BSRAM_BASE_DEFAULT = 24'h800000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR     = 2'd1,
        ST_ROM_RD = 2'd2,
        ST_BS_RD  = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic [BS_AW-1:0] addr;
        logic [BS_DW-1:0] data;
    } bsram_wr_t;

    // Word address of a BSRAM byte; the 24-bit sum wraps naturally.
    function automatic logic [MEM_AW-1:0] bs_word_addr(
        input logic [MEM_AW-1:0] base,
        input logic [BS_AW-2:0]  word_idx
    );
        return base + {{(MEM_AW-BS_AW+1){1'b0}}, word_idx};
    endfunction

    function automatic logic [MEM_BEW-1:0] bs_byte_en(input logic odd);
        return odd ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bsram_wr_fifo.sv
// Two-entry BSRAM write buffer. The head stays put until the backend
// acknowledges it, so a simultaneous push and pop on a full buffer is accepted.
module bsram_wr_fifo
    import snes_mem_pkg::*;
(
    input  logic      clk,
    input  logic      srst,
    input  logic      push,
    input  bsram_wr_t push_data,
    input  logic      pop,
    output bsram_wr_t head,
    output logic      full,
    output logic      empty
);

    localparam int DEPTH = 2;

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       push_ok;
    logic       pop_ok;
    bsram_wr_t  slot [DEPTH];

    assign full    = (count_reg == 2'd2);
    assign empty   = (count_reg == 2'd0);
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign head    = slot[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            bsram_wr_t data_reg;
            always_ff @(posedge clk) begin
                if (srst) begin
                    data_reg <= '0;
                end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= push_data;
                end
            end
            assign slot[gi] = data_reg;
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/snes_cart_mem_responder.sv
// Serves mapper ROM/BSRAM strobes from one request/ack backend port, with a
// one-word ROM fetch tag, a last-read BSRAM byte and a buffered write path.
module snes_cart_mem_responder
    import snes_mem_pkg::*;
#(
    parameter logic [MEM_AW-1:0] BSRAM_BASE = BSRAM_BASE_DEFAULT
) (
    input  logic               mclk,
    input  logic               rst,
    input  logic [23:0]        rom_addr,
    input  logic               rom_ce_n,
    input  logic               rom_oe_n,
    input  logic               rom_word,
    output logic [15:0]        rom_q,
    input  logic [BS_AW-1:0]   bsram_addr,
    input  logic [BS_DW-1:0]   bsram_d,
    input  logic               bsram_ce_n,
    input  logic               bsram_oe_n,
    input  logic               bsram_we_n,
    output logic [BS_DW-1:0]   bsram_q,
    output logic               mem_req,
    output logic               mem_we,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic [MEM_BEW-1:0] mem_be,
    output logic [MEM_DW-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic [MEM_DW-1:0]  mem_rdata,
    output logic               wr_overrun
);

    mem_state_e          state_reg;
    logic                mem_req_reg;
    logic                mem_we_reg;
    logic [MEM_AW-1:0]   mem_addr_reg;
    logic [MEM_BEW-1:0]  mem_be_reg;
    logic [MEM_DW-1:0]   mem_wdata_reg;

    logic [MEM_DW-1:0]   rom_data_reg;
    logic [22:0]         rom_tag_reg;
    logic                rom_tag_valid_reg;

    logic [BS_DW-1:0]    bsram_q_reg;
    logic [BS_AW-1:0]    bs_tag_reg;
    logic                bs_valid_reg;
    logic [BS_AW-1:0]    bs_rd_addr_reg;
    logic                bs_rd_stale_reg;

    logic                we_n_prev_reg;
    logic                wr_overrun_reg;

    logic                rom_sel;
    logic                rom_miss;
    logic                bs_rd_miss;
    logic                wr_fall;
    logic                bs_wr_hits_tag;
    logic                bs_wr_hits_rd;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                overrun_set;
    bsram_wr_t           fifo_head;
    bsram_wr_t           fifo_push_data;

    assign rom_sel    = ~rom_ce_n & ~rom_oe_n;
    assign rom_miss   = rom_sel & ~(rom_tag_valid_reg && (rom_tag_reg == rom_addr[23:1]));
    assign bs_rd_miss = ~bsram_ce_n & ~bsram_oe_n & bsram_we_n
                      & ~(bs_valid_reg && (bs_tag_reg == bsram_addr));

    assign wr_fall        = we_n_prev_reg & ~bsram_we_n & ~bsram_ce_n;
    assign bs_wr_hits_tag = wr_fall & (bsram_addr == bs_tag_reg);
    assign bs_wr_hits_rd  = wr_fall & (state_reg == ST_BS_RD) & (bsram_addr == bs_rd_addr_reg);

    // The write entry leaves the buffer only once the backend has taken it.
    assign fifo_pop       = (state_reg == ST_WR) & mem_ack;
    assign overrun_set    = wr_fall & fifo_full & ~fifo_pop;
    assign fifo_push_data = '{addr: bsram_addr, data: bsram_d};

    bsram_wr_fifo u_wr_fifo (
        .clk       (mclk),
        .srst      (rst),
        .push      (wr_fall),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        if (rom_word) begin
            rom_q = rom_data_reg;
        end else if (rom_addr[0]) begin
            rom_q = {2{rom_data_reg[15:8]}};
        end else begin
            rom_q = {2{rom_data_reg[7:0]}};
        end
    end

    assign bsram_q    = bsram_q_reg;
    assign mem_req    = mem_req_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_be     = mem_be_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign wr_overrun = wr_overrun_reg;

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            mem_req_reg       <= 1'b0;
            mem_we_reg        <= 1'b0;
            mem_addr_reg      <= '0;
            mem_be_reg        <= '0;
            mem_wdata_reg     <= '0;
            rom_data_reg      <= '0;
            rom_tag_reg       <= '0;
            rom_tag_valid_reg <= 1'b0;
            bsram_q_reg       <= '0;
            bs_tag_reg        <= '0;
            bs_valid_reg      <= 1'b0;
            bs_rd_addr_reg    <= '0;
            bs_rd_stale_reg   <= 1'b0;
            we_n_prev_reg     <= 1'b1;
            wr_overrun_reg    <= 1'b0;
        end else begin
            we_n_prev_reg <= bsram_we_n;
            if (overrun_set)    wr_overrun_reg  <= 1'b1;
            if (bs_wr_hits_tag) bs_valid_reg    <= 1'b0;
            if (bs_wr_hits_rd)  bs_rd_stale_reg <= 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_reg     <= ST_WR;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= bs_word_addr(BSRAM_BASE, fifo_head.addr[BS_AW-1:1]);
                        mem_be_reg    <= bs_byte_en(fifo_head.addr[0]);
                        mem_wdata_reg <= {2{fifo_head.data}};
                    end else if (rom_miss) begin
                        state_reg    <= ST_ROM_RD;
                        mem_req_reg  <= 1'b1;
                        mem_we_reg   <= 1'b0;
                        mem_addr_reg <= {1'b0, rom_addr[23:1]};
                        mem_be_reg   <= 2'b11;
                    end else if (bs_rd_miss) begin
                        state_reg       <= ST_BS_RD;
                        mem_req_reg     <= 1'b1;
                        mem_we_reg      <= 1'b0;
                        mem_addr_reg    <= bs_word_addr(BSRAM_BASE, bsram_addr[BS_AW-1:1]);
                        mem_be_reg      <= bs_byte_en(bsram_addr[0]);
                        bs_rd_addr_reg  <= bsram_addr;
                        bs_rd_stale_reg <= 1'b0;
                    end
                end
                ST_WR: begin
                    if (mem_ack) begin
                        state_reg   <= ST_IDLE;
                        mem_req_reg <= 1'b0;
                    end
                end
                ST_ROM_RD: begin
                    // Tag follows the fetched word, not the current bus address.
                    if (mem_ack) begin
                        state_reg         <= ST_IDLE;
                        mem_req_reg       <= 1'b0;
                        rom_data_reg      <= mem_rdata;
                        rom_tag_reg       <= mem_addr_reg[22:0];
                        rom_tag_valid_reg <= 1'b1;
                    end
                end
                ST_BS_RD: begin
                    if (mem_ack) begin
                        state_reg    <= ST_IDLE;
                        mem_req_reg  <= 1'b0;
                        bsram_q_reg  <= mem_be_reg[1] ? mem_rdata[15:8] : mem_rdata[7:0];
                        bs_tag_reg   <= bs_rd_addr_reg;
                        bs_valid_reg <= ~(bs_rd_stale_reg | bs_wr_hits_rd);
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snes_cart_mem_responder.sv
// Bench for snes_cart_mem_responder: a backend memory model with a request
// scoreboard, a vector table of ROM/BSRAM reads, and multi-cycle sequences.
`timescale 1ns/1ps
module tb_snes_cart_mem_responder;

    logic        mclk = 1'b0;
    logic        rst;
    logic [23:0] rom_addr;
    logic        rom_ce_n, rom_oe_n, rom_word;
    logic [15:0] rom_q;
    logic [19:0] bsram_addr;
    logic [7:0]  bsram_d;
    logic        bsram_ce_n, bsram_oe_n, bsram_we_n;
    logic [7:0]  bsram_q;
    logic        mem_req, mem_we;
    logic [23:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        wr_overrun;

    always #5 mclk = ~mclk;

    snes_cart_mem_responder dut (
        .mclk       (mclk),
        .rst        (rst),
        .rom_addr   (rom_addr),
        .rom_ce_n   (rom_ce_n),
        .rom_oe_n   (rom_oe_n),
        .rom_word   (rom_word),
        .rom_q      (rom_q),
        .bsram_addr (bsram_addr),
        .bsram_d    (bsram_d),
        .bsram_ce_n (bsram_ce_n),
        .bsram_oe_n (bsram_oe_n),
        .bsram_we_n (bsram_we_n),
        .bsram_q    (bsram_q),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wr_overrun (wr_overrun)
    );

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } req_t;

    typedef struct {
        bit          is_bs;
        logic [23:0] addr;
        bit          word;
        logic [15:0] exp;
        bit          fetch;
    } vec_t;

    localparam int NV = 11;

    vec_t        vecs [NV];
    req_t        exp_q [$];
    logic [15:0] bmem [logic [23:0]];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          req_count = 0;
    int          ack_count = 0;
    int          lat = 5;
    bit          hold_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [23:0] bs_waddr(input logic [19:0] a);
        return 24'h800000 + {5'd0, a[19:1]};
    endfunction

    // Backend: scoreboard each new request, then ack after lat cycles.
    initial begin : backend
        req_t        cur;
        logic [15:0] w;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge mclk); #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                cur = '{we: mem_we, addr: mem_addr, be: mem_be, wdata: mem_wdata};
                req_count++;
                $display("txn %0d: we=%b addr=%h be=%b wdata=%h", req_count, cur.we, cur.addr, cur.be, cur.wdata);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr %h we %b, required no request", cur.addr, cur.we);
                end else begin
                    req_t e;
                    e = exp_q.pop_front();
                    check("req_we",   32'(cur.we),   32'(e.we));
                    check("req_addr", 32'(cur.addr), 32'(e.addr));
                    check("req_be",   32'(cur.be),   32'(e.be));
                    if (e.we) check("req_wdata", 32'(cur.wdata), 32'(e.wdata));
                end
                for (int k = 0; k < lat; k++) @(posedge mclk);
                while (hold_ack) @(posedge mclk);
                #1;
                if (mem_req) begin
                    check("hold_addr", 32'(mem_addr), 32'(cur.addr));
                    check("hold_be",   32'(mem_be),   32'(cur.be));
                end
                w = bmem.exists(cur.addr) ? bmem[cur.addr] : 16'h0000;
                if (cur.we) begin
                    if (cur.be[0]) w[7:0]  = cur.wdata[7:0];
                    if (cur.be[1]) w[15:8] = cur.wdata[15:8];
                    bmem[cur.addr] = w;
                end else begin
                    mem_rdata = w;
                end
                mem_ack = 1'b1;
                ack_count++;
            end
        end
    end

    task automatic wait_acks(input int target, input string name);
        int cyc = 0;
        while (ack_count < target && cyc < 300) begin
            @(negedge mclk);
            cyc++;
        end
        check({name, "_ack_timeout"}, 32'(ack_count >= target), 32'd1);
        @(posedge mclk);
        @(negedge mclk);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   a0, r0;
        req_t e;
        a0 = ack_count;
        r0 = req_count;
        if (v.fetch) begin
            if (v.is_bs) e = '{we: 1'b0, addr: bs_waddr(v.addr[19:0]), be: (v.addr[0] ? 2'b10 : 2'b01), wdata: 16'h0};
            else         e = '{we: 1'b0, addr: {1'b0, v.addr[23:1]}, be: 2'b11, wdata: 16'h0};
            exp_q.push_back(e);
        end
        @(negedge mclk);
        if (v.is_bs) begin
            bsram_addr = v.addr[19:0];
            bsram_we_n = 1'b1;
            bsram_oe_n = 1'b0;
            bsram_ce_n = 1'b0;
        end else begin
            rom_addr = v.addr;
            rom_word = v.word;
            rom_ce_n = 1'b0;
            rom_oe_n = 1'b0;
        end
        if (v.fetch) wait_acks(a0 + 1, tag);
        else repeat (4) @(negedge mclk);
        check({tag, "_nreq"}, 32'(req_count), 32'(r0 + (v.fetch ? 1 : 0)));
        if (v.is_bs) check({tag, "_bsram_q"}, 32'(bsram_q), 32'(v.exp[7:0]));
        else         check({tag, "_rom_q"},   32'(rom_q),   32'(v.exp));
        rom_ce_n   = 1'b1;
        rom_oe_n   = 1'b1;
        bsram_ce_n = 1'b1;
        bsram_oe_n = 1'b1;
    endtask

    task automatic bs_write(input logic [19:0] a, input logic [7:0] d, input bit expect_issue);
        if (expect_issue)
            exp_q.push_back('{we: 1'b1, addr: bs_waddr(a), be: (a[0] ? 2'b10 : 2'b01), wdata: {d, d}});
        @(negedge mclk);
        bsram_addr = a;
        bsram_d    = d;
        bsram_oe_n = 1'b1;
        bsram_we_n = 1'b1;
        bsram_ce_n = 1'b0;
        @(negedge mclk);
        bsram_we_n = 1'b0;
        @(negedge mclk);
        bsram_we_n = 1'b1;
        @(negedge mclk);
        bsram_ce_n = 1'b1;
    endtask

    initial begin : main
        int   a0, r0, cyc;
        vec_t v;

        rst = 1'b1;
        rom_addr = '0; rom_ce_n = 1'b1; rom_oe_n = 1'b1; rom_word = 1'b0;
        bsram_addr = '0; bsram_d = '0;
        bsram_ce_n = 1'b1; bsram_oe_n = 1'b1; bsram_we_n = 1'b1;

        bmem[24'h000091] = 16'hBEEF;
        bmem[24'h3FFFFF] = 16'h1234;
        bmem[24'h7FFFFF] = 16'hC0DE;
        bmem[24'h800008] = 16'h7788;
        bmem[24'h87FFFF] = 16'h3C00;
        bmem[24'h800011] = 16'h4455;
        bmem[24'h800020] = 16'h2211;
        bmem[24'h000200] = 16'h1357;
        bmem[24'h000300] = 16'h2468;
        bmem[24'h000100] = 16'h5AC3;

        vecs[0]  = '{1'b0, 24'h000123, 1'b0, 16'hBEBE, 1'b1};
        vecs[1]  = '{1'b0, 24'h000122, 1'b0, 16'hEFEF, 1'b0};
        vecs[2]  = '{1'b0, 24'h000123, 1'b1, 16'hBEEF, 1'b0};
        vecs[3]  = '{1'b0, 24'h7FFFFE, 1'b1, 16'h1234, 1'b1};
        vecs[4]  = '{1'b0, 24'hFFFFFF, 1'b0, 16'hC0C0, 1'b1};
        vecs[5]  = '{1'b0, 24'hFFFFFE, 1'b0, 16'hDEDE, 1'b0};
        vecs[6]  = '{1'b1, 24'h000010, 1'b0, 16'h0088, 1'b1};
        vecs[7]  = '{1'b1, 24'h000011, 1'b0, 16'h0077, 1'b1};
        vecs[8]  = '{1'b1, 24'h000011, 1'b0, 16'h0077, 1'b0};
        vecs[9]  = '{1'b1, 24'h0FFFFF, 1'b0, 16'h003C, 1'b1};
        vecs[10] = '{1'b0, 24'hFFFFFF, 1'b1, 16'hC0DE, 1'b0};

        repeat (3) @(negedge mclk);
        check("rst_rom_q",      32'(rom_q),      32'h0);
        check("rst_bsram_q",    32'(bsram_q),    32'h0);
        check("rst_mem_req",    32'(mem_req),    32'h0);
        check("rst_mem_we",     32'(mem_we),     32'h0);
        check("rst_mem_addr",   32'(mem_addr),   32'h0);
        check("rst_mem_be",     32'(mem_be),     32'h0);
        check("rst_mem_wdata",  32'(mem_wdata),  32'h0);
        check("rst_wr_overrun", 32'(wr_overrun), 32'h0);
        rst = 1'b0;
        @(negedge mclk);

        for (int i = 0; i < NV; i++) begin
            lat = (i == 0) ? 5 : 1 + (i % 3);
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Single BSRAM write: odd byte lands in the high lane.
        lat = 2;
        a0 = ack_count;
        bs_write(20'h00005, 8'hA5, 1'b1);
        wait_acks(a0 + 1, "wr_single");

        // Three writes with the backend stalled: third is dropped.
        lat = 3;
        hold_ack = 1'b1;
        a0 = ack_count;
        r0 = req_count;
        bs_write(20'h00020, 8'h11, 1'b1);
        bs_write(20'h00021, 8'h22, 1'b1);
        check("ovr_before", 32'(wr_overrun), 32'h0);
        bs_write(20'h00022, 8'h33, 1'b0);
        check("ovr_after", 32'(wr_overrun), 32'h1);
        repeat (2) @(negedge mclk);
        hold_ack = 1'b0;
        wait_acks(a0 + 2, "ovr_drain");
        repeat (6) @(negedge mclk);
        check("ovr_nreq", 32'(req_count), 32'(r0 + 2));
        v = '{1'b1, 24'h000021, 1'b0, 16'h0022, 1'b1};
        run_vec(v, "ovr_rd21");
        v = '{1'b1, 24'h000022, 1'b0, 16'h0055, 1'b1};
        run_vec(v, "ovr_rd22");

        // Write and ROM miss both pending when the backend frees up.
        lat = 2;
        v = '{1'b1, 24'h000040, 1'b0, 16'h0011, 1'b1};
        run_vec(v, "arb_pre_rd");
        hold_ack = 1'b1;
        a0 = ack_count;
        exp_q.push_back('{we: 1'b0, addr: 24'h000200, be: 2'b11, wdata: 16'h0});
        @(negedge mclk);
        rom_addr = 24'h000400; rom_word = 1'b0; rom_ce_n = 1'b0; rom_oe_n = 1'b0;
        repeat (3) @(negedge mclk);
        rom_addr = 24'h000600;
        bs_write(20'h00040, 8'h99, 1'b1);
        exp_q.push_back('{we: 1'b0, addr: 24'h000300, be: 2'b11, wdata: 16'h0});
        hold_ack = 1'b0;
        wait_acks(a0 + 3, "arb_drain");
        check("arb_rom_q", 32'(rom_q), 32'h6868);
        rom_ce_n = 1'b1; rom_oe_n = 1'b1;
        v = '{1'b1, 24'h000040, 1'b0, 16'h0099, 1'b1};
        run_vec(v, "arb_refetch");

        // Reset while a ROM fetch is outstanding, then a stale ack.
        hold_ack = 1'b1;
        a0 = ack_count;
        r0 = req_count;
        exp_q.push_back('{we: 1'b0, addr: 24'h000100, be: 2'b11, wdata: 16'h0});
        @(negedge mclk);
        rom_addr = 24'h000200; rom_word = 1'b0; rom_ce_n = 1'b0; rom_oe_n = 1'b0;
        cyc = 0;
        while (req_count < r0 + 1 && cyc < 50) begin
            @(negedge mclk);
            cyc++;
        end
        check("rstmid_req_seen", 32'(req_count), 32'(r0 + 1));
        @(negedge mclk);
        rst = 1'b1;
        rom_ce_n = 1'b1; rom_oe_n = 1'b1;
        @(negedge mclk);
        rst = 1'b0;
        hold_ack = 1'b0;
        wait_acks(a0 + 1, "rstmid_stale");
        repeat (2) @(negedge mclk);
        check("rstmid_mem_req",    32'(mem_req),    32'h0);
        check("rstmid_rom_q",      32'(rom_q),      32'h0);
        check("rstmid_bsram_q",    32'(bsram_q),    32'h0);
        check("rstmid_mem_addr",   32'(mem_addr),   32'h0);
        check("rstmid_wr_overrun", 32'(wr_overrun), 32'h0);
        v = '{1'b0, 24'h000200, 1'b0, 16'hC3C3, 1'b1};
        run_vec(v, "rstmid_refetch");

        repeat (4) @(negedge mclk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
